// File: rtl/dht22_pkg.sv
// Shared definitions for the DHT22 sample post-processor: register map,
// FSM encoding, CTRL/STATUS bit positions, default range limits and a
// saturating counter helper.
package dht22_pkg;

  // Register word addresses
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LATEST = 3'd2;
  localparam logic [2:0] REG_MIN    = 3'd3;
  localparam logic [2:0] REG_MAX    = 3'd4;
  localparam logic [2:0] REG_AVG    = 3'd5;
  localparam logic [2:0] REG_COUNT  = 3'd6;

  // Sample pipeline states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // CTRL bit positions
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_CLR_MINMAX = 2;
  localparam int CTRL_CLR_AVG    = 3;

  // STATUS bit positions
  localparam int STS_NEW       = 0;
  localparam int STS_RANGE_ERR = 1;
  localparam int STS_OVERRUN   = 2;
  localparam int STS_AVG_RDY   = 3;

  // Default legal ranges (0.1 %RH and 0.1 degC units)
  localparam int AVG_LOG2_DEF = 2;
  localparam int HUM_MAX_DEF  = 1000;
  localparam int TEMP_MIN_DEF = -400;
  localparam int TEMP_MAX_DEF = 800;

  // Counter next value: optional clear first, then a saturating increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt,
                                          input logic        clr,
                                          input logic        inc);
    logic [15:0] base;
    base = clr ? 16'd0 : cnt;
    return (inc && (base != 16'hFFFF)) ? base + 16'd1 : base;
  endfunction

endpackage

// File: rtl/dht22_avg_acc.sv
// Block averager: sums 2^AVG_LOG2 accepted samples, then publishes
// floor(sum / 2^AVG_LOG2) for humidity (unsigned) and temperature (signed).
// A clear restarts the window; a sample added in the same cycle opens the new one.
module dht22_avg_acc
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               res,
  input  logic               add,
  input  logic               clr,
  input  logic [15:0]        hum,
  input  logic signed [15:0] temp,
  output logic [15:0]        avg_hum,
  output logic signed [15:0] avg_temp,
  output logic               avg_rdy_pulse
);

  localparam int SW = 16 + AVG_LOG2;

  logic [SW-1:0]        hum_sum_q, hum_sum_d, hum_base, hum_tot;
  logic signed [SW-1:0] temp_sum_q, temp_sum_d, temp_base, temp_tot;
  logic [AVG_LOG2-1:0]  win_cnt_q, win_cnt_d, cnt_base;
  logic [15:0]          avg_hum_q;
  logic signed [15:0]   avg_temp_q;
  logic                 win_last;

  // Window bookkeeping: apply clear first, then fold in the new sample
  always_comb begin
    hum_base   = clr ? '0 : hum_sum_q;
    temp_base  = clr ? '0 : temp_sum_q;
    cnt_base   = clr ? '0 : win_cnt_q;
    hum_tot    = hum_base + {{AVG_LOG2{1'b0}}, hum};
    temp_tot   = temp_base + {{AVG_LOG2{temp[15]}}, temp};
    win_last   = add && (cnt_base == '1);
    hum_sum_d  = hum_base;
    temp_sum_d = temp_base;
    win_cnt_d  = cnt_base;
    if (add) begin
      if (win_last) begin
        hum_sum_d  = '0;
        temp_sum_d = '0;
        win_cnt_d  = '0;
      end else begin
        hum_sum_d  = hum_tot;
        temp_sum_d = temp_tot;
        win_cnt_d  = cnt_base + AVG_LOG2'(1);
      end
    end
  end

  // Accumulator state and the published averages (top 16 bits = shifted sum)
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hum_sum_q  <= '0;
      temp_sum_q <= '0;
      win_cnt_q  <= '0;
      avg_hum_q  <= '0;
      avg_temp_q <= '0;
    end else begin
      hum_sum_q  <= hum_sum_d;
      temp_sum_q <= temp_sum_d;
      win_cnt_q  <= win_cnt_d;
      if (win_last) begin
        avg_hum_q  <= hum_tot[SW-1:AVG_LOG2];
        avg_temp_q <= temp_tot[SW-1:AVG_LOG2];
      end
    end
  end

  assign avg_hum       = avg_hum_q;
  assign avg_temp      = avg_temp_q;
  assign avg_rdy_pulse = win_last;

endmodule

// File: rtl/dht22_sample_proc.sv
// DHT22 sample post-processor: decode, range-check, min/max, block average,
// good/bad counters and a CPU register port with a level interrupt.
// Sample effects land 3 cycles after data_valid; pulses while busy are dropped.
module dht22_sample_proc
  import dht22_pkg::*;
#(
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int HUM_MAX  = HUM_MAX_DEF,
  parameter int TEMP_MIN = TEMP_MIN_DEF,
  parameter int TEMP_MAX = TEMP_MAX_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e             state_q, state_d;
  logic [31:0]        raw_q;
  logic [15:0]        hum_q;
  logic signed [15:0] temp_q;
  logic               ok_q;
  logic               enable_q, irq_en_q;
  logic [3:0]         status_q, status_d, sts_set, sts_w1c;
  logic [31:0]        latest_q;
  logic [15:0]        hum_min_q, hum_max_q;
  logic signed [15:0] temp_min_q, temp_max_q;
  logic               mm_valid_q, mm_base_valid;
  logic [15:0]        sample_cnt_q, err_cnt_q;
  logic [31:0]        rdata_q, rd_mux;

  logic               wr, rd, ctrl_wr, count_wr, clr_minmax, clr_avg;
  logic               accept, overrun, upd_ok, upd_bad;
  logic [15:0]        chk_hum, chk_mag, chk_temp;
  logic signed [31:0] chk_temp32;
  logic               chk_ok;
  logic [15:0]        avg_hum;
  logic signed [15:0] avg_temp;
  logic               avg_rdy_pulse;
  logic               unused_wdata;

  assign wr         = sel & we;
  assign rd         = sel & ~we;
  assign ctrl_wr    = wr & (addr == REG_CTRL);
  assign count_wr   = wr & (addr == REG_COUNT);
  assign clr_minmax = ctrl_wr & wdata[CTRL_CLR_MINMAX];
  assign clr_avg    = ctrl_wr & wdata[CTRL_CLR_AVG];
  assign sts_w1c    = (wr && (addr == REG_STATUS)) ? wdata[3:0] : 4'd0;
  assign unused_wdata = ^wdata[31:4];

  assign accept  = data_valid & enable_q & (state_q == ST_IDLE);
  assign overrun = data_valid & enable_q & (state_q != ST_IDLE);
  assign upd_ok  = (state_q == ST_UPDATE) & ok_q;
  assign upd_bad = (state_q == ST_UPDATE) & ~ok_q;

  // Sign-magnitude temperature to two's complement, plus the range check
  assign chk_hum    = raw_q[31:16];
  assign chk_mag    = {1'b0, raw_q[14:0]};
  assign chk_temp   = raw_q[15] ? (16'd0 - chk_mag) : chk_mag;
  assign chk_temp32 = {{16{chk_temp[15]}}, chk_temp};
  assign chk_ok     = ({16'd0, chk_hum} <= HUM_MAX) &&
                      (chk_temp32 >= TEMP_MIN) && (chk_temp32 <= TEMP_MAX);

  // Sample pipeline next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sample pipeline state register
  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Hardware set beats a same-cycle W1C
  always_comb begin
    sts_set                = 4'd0;
    sts_set[STS_NEW]       = upd_ok;
    sts_set[STS_RANGE_ERR] = upd_bad;
    sts_set[STS_OVERRUN]   = overrun;
    sts_set[STS_AVG_RDY]   = avg_rdy_pulse;
    status_d               = (status_q & ~sts_w1c) | sts_set;
  end

  // Raw capture, decoded sample, control, status and counters
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      raw_q        <= '0;
      hum_q        <= '0;
      temp_q       <= '0;
      ok_q         <= 1'b0;
      enable_q     <= 1'b1;
      irq_en_q     <= 1'b0;
      status_q     <= '0;
      latest_q     <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (accept) raw_q <= data_in;
      if (state_q == ST_CHECK) begin
        hum_q  <= chk_hum;
        temp_q <= chk_temp;
        ok_q   <= chk_ok;
      end
      if (ctrl_wr) begin
        enable_q <= wdata[CTRL_ENABLE];
        irq_en_q <= wdata[CTRL_IRQ_EN];
      end
      status_q     <= status_d;
      if (upd_ok) latest_q <= {hum_q, temp_q};
      sample_cnt_q <= sat_inc(sample_cnt_q, count_wr, upd_ok);
      err_cnt_q    <= sat_inc(err_cnt_q, count_wr, upd_bad);
    end
  end

  // A clear in the update cycle makes the new sample the first min/max value
  assign mm_base_valid = mm_valid_q & ~clr_minmax;

  // Independent min/max tracking for humidity (unsigned) and temperature (signed)
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mm_valid_q <= 1'b0;
      hum_min_q  <= '0;
      hum_max_q  <= '0;
      temp_min_q <= '0;
      temp_max_q <= '0;
    end else if (upd_ok) begin
      mm_valid_q <= 1'b1;
      if (!mm_base_valid || (hum_q < hum_min_q))   hum_min_q  <= hum_q;
      if (!mm_base_valid || (hum_q > hum_max_q))   hum_max_q  <= hum_q;
      if (!mm_base_valid || (temp_q < temp_min_q)) temp_min_q <= temp_q;
      if (!mm_base_valid || (temp_q > temp_max_q)) temp_max_q <= temp_q;
    end else if (clr_minmax) begin
      mm_valid_q <= 1'b0;
    end
  end

  dht22_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk           (clk),
    .res           (res),
    .add           (upd_ok),
    .clr           (clr_avg),
    .hum           (hum_q),
    .temp          (temp_q),
    .avg_hum       (avg_hum),
    .avg_temp      (avg_temp),
    .avg_rdy_pulse (avg_rdy_pulse)
  );

  // Read data selection
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL:   rd_mux = {30'd0, irq_en_q, enable_q};
      REG_STATUS: rd_mux = {28'd0, status_q};
      REG_LATEST: rd_mux = latest_q;
      REG_MIN:    rd_mux = mm_valid_q ? {hum_min_q, temp_min_q} : 32'd0;
      REG_MAX:    rd_mux = mm_valid_q ? {hum_max_q, temp_max_q} : 32'd0;
      REG_AVG:    rd_mux = {avg_hum, avg_temp};
      REG_COUNT:  rd_mux = {err_cnt_q, sample_cnt_q};
      default:    rd_mux = '0;
    endcase
  end

  // Registered read port, holds its value between reads
  always_ff @(posedge clk or posedge res) begin
    if (res)     rdata_q <= '0;
    else if (rd) rdata_q <= rd_mux;
  end

  assign rdata = rdata_q;
  assign irq   = irq_en_q & (status_q[STS_NEW] | status_q[STS_RANGE_ERR] |
                             status_q[STS_OVERRUN]);

endmodule
